neuron_mac_fix: RTL and testbench

- Sequential fixed-point neuron that computes the pre-activation value y = sum(x[i]*w[i]) + bias over N_INPUTS streamed operand pairs.
- Result is rounded back to WIDTH bits and saturated; it feeds relu_fix directly (out goes to relu_fix.in).
- Sits inside a dense layer; one instance per neuron, or time-multiplexed by the layer controller.

---
 rtl/nn_fix_pkg.sv | 21 ++
 rtl/round_sat_fix.sv | 34 +++
 rtl/neuron_mac_fix.sv | 111 +++++++++++
 tb/tb_neuron_mac_fix.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/nn_fix_pkg.sv
// nn_fix_pkg: shared fixed-point defaults, saturation helper and neuron FSM states.
// Contents:
//   WIDTH_DEF / FRAC_DEF  default Q-format (signed 16-bit, 8 fractional bits)
//   state_t               neuron evaluation states IDLE, ACC, FIN, DONE
//   sat_fix(value, width) clip a signed value into the signed range of width bits
package nn_fix_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int FRAC_DEF  = 8;

    typedef enum logic [1:0] {IDLE, ACC, FIN, DONE} state_t;

    function automatic logic signed [63:0] sat_fix(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction

endpackage

// File: rtl/round_sat_fix.sv
// round_sat_fix: combinational round-half-up, bias add and saturation of a wide accumulator.
// Ports:
//   acc   in   ACC_W  signed Q(2*FRAC) accumulator
//   bias  in   WIDTH  signed Q(FRAC) bias
//   sat   out  1      result was clipped (only with NEURON_MAC_SAT_FLAG_EN)
//   out   out  WIDTH  signed Q(FRAC) saturated result
// Assumes FRAC >= 1 and ACC_W + 2 <= 64.
module round_sat_fix
    import nn_fix_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = 2 * WIDTH_DEF + 11
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [WIDTH-1:0] bias,
`ifdef NEURON_MAC_SAT_FLAG_EN
    output logic                    sat,
`endif
    output logic signed [WIDTH-1:0] out
);

    logic signed [63:0] s;

    always_comb begin
        // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
        s   = ((64'(acc) + (64'sd1 <<< (FRAC - 1))) >>> FRAC) + 64'(bias);
        out = WIDTH'(sat_fix(s, WIDTH));
`ifdef NEURON_MAC_SAT_FLAG_EN
        sat = sat_fix(s, WIDTH) != s;
`endif
    end

endmodule

// File: rtl/neuron_mac_fix.sv
// neuron_mac_fix: sequential fixed-point neuron, out = sat(round(sum(x*w)) + bias).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, bias          begin evaluation (sampled in IDLE), bias captured on acceptance
//   in_valid, in_ready   x/w operand pair handshake
//   x, w                 signed Q(FRAC) activation and weight
//   out_valid, out_ready result handshake
//   out                  signed saturated pre-activation, held until the next evaluation
//   sat                  clip flag, present only when NEURON_MAC_SAT_FLAG_EN is defined
//   busy                 high whenever not IDLE
module neuron_mac_fix
    import nn_fix_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int N_INPUTS = 784
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out,
`ifdef NEURON_MAC_SAT_FLAG_EN
    output logic                    sat,
`endif
    output logic                    busy
);

    localparam int ACC_W = 2 * WIDTH + $clog2(N_INPUTS) + 1;
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                    state, nxt;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic signed [WIDTH-1:0]   bias_q, rs_out;
    logic signed [2*WIDTH-1:0] prod;
    logic                      beat, last;
`ifdef NEURON_MAC_SAT_FLAG_EN
    logic                      rs_sat;
`endif

    assign prod = (2*WIDTH)'(x) * (2*WIDTH)'(w);
    assign beat = in_valid && in_ready;
    assign last = cnt == CNT_W'(N_INPUTS - 1);

    round_sat_fix #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_rs (
        .acc  (acc),
        .bias (bias_q),
`ifdef NEURON_MAC_SAT_FLAG_EN
        .sat  (rs_sat),
`endif
        .out  (rs_out)
    );

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE: nxt = start ? ACC : IDLE;
            ACC: begin
                in_ready = 1'b1;
                nxt      = (in_valid && last) ? FIN : ACC;
            end
            FIN:  nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                nxt       = out_ready ? IDLE : DONE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            bias_q <= '0;
            out    <= '0;
`ifdef NEURON_MAC_SAT_FLAG_EN
            sat    <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                acc    <= '0;
                cnt    <= '0;
                bias_q <= bias;
            end
            if (beat) begin
                acc <= acc + ACC_W'(prod);
                cnt <= cnt + 1'b1;
            end
            if (state == FIN) begin
                out <= rs_out;
`ifdef NEURON_MAC_SAT_FLAG_EN
                sat <= rs_sat;
`endif
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_fix.sv
// tb_neuron_mac_fix: directed and randomized checks of neuron_mac_fix against an arithmetic model.
module tb_neuron_mac_fix;

    localparam int W = 16;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] bias = '0;
    logic signed [W-1:0] x = '0;
    logic signed [W-1:0] w = '0;
    logic signed [W-1:0] out;
    logic                in_ready, out_valid, busy;
`ifdef NEURON_MAC_SAT_FLAG_EN
    logic                sat;
`endif

    int     checks = 0;
    int     errors = 0;
    longint xs[N];
    longint ws[N];

    always #5 clk = ~clk;

    neuron_mac_fix #(.WIDTH(W), .FRAC(8), .N_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
`ifdef NEURON_MAC_SAT_FLAG_EN
        .sat       (sat),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Real-valued meaning: floor(sum/256 + 0.5) + bias, clipped to 16-bit signed.
    function automatic longint model(input longint b, output bit clip);
        longint y, n, r, s;
        y = 0;
        for (int i = 0; i < N; i++) y += xs[i] * ws[i];
        n = y + 128;
        r = n >= 0 ? n / 256 : -((-n + 255) / 256);
        s = r + b;
        clip = s > 32767 || s < -32768;
        return s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
    endfunction

    task automatic run(input longint b, input int gap, input int hold);
        longint              exp;
        bit                  clip;
        logic signed [W-1:0] held;
        exp = model(b, clip);
        @(negedge clk);
        start = 1'b1;
        bias  = W'(b);
        @(negedge clk);
        start = 1'b0;
        bias  = W'($urandom);
        chk("busy_acc", longint'(busy), 1);
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, gap)) begin
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            start    = 1'b0;
            in_valid = 1'b1;
            x        = W'(xs[i]);
            w        = W'(ws[i]);
            chk("in_ready", longint'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            x        = W'($urandom);
            w        = W'($urandom);
        end
        chk("fin_out_valid", longint'(out_valid), 0);
        chk("fin_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        chk("out_valid", longint'(out_valid), 1);
        chk("out", longint'(out), exp);
`ifdef NEURON_MAC_SAT_FLAG_EN
        chk("sat", longint'(sat), longint'(clip));
`endif
        held = out;
        repeat (hold) begin
            start = 1'b1;
            @(negedge clk);
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_out", longint'(out), longint'(held));
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        chk("exit_valid", longint'(out_valid), 0);
        chk("exit_busy", longint'(busy), 0);
        chk("out_kept", longint'(out), longint'(held));
    endtask

    task automatic fill(input longint xv, input longint wv);
        for (int i = 0; i < N; i++) begin
            xs[i] = xv;
            ws[i] = wv;
        end
    endtask

    initial begin
        #12;
        chk("rst_out", longint'(out), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        rst_n = 1'b1;

        fill(256, 128);       run(0, 0, 0);
        chk("basic_512", longint'(out), 512);
        fill(256, -256);      run(256, 0, 0);
        chk("neg_bias", longint'(out), -768);
        fill(1, 64);          run(0, 0, 0);
        chk("round_up", longint'(out), 1);
        fill(1, -64);         run(0, 0, 0);
        chk("round_neg", longint'(out), -1);
        fill(32767, 32767);   run(32767, 0, 0);
        chk("sat_hi", longint'(out), 32767);
        fill(32767, -32768);  run(0, 0, 0);
        chk("sat_lo", longint'(out), -32768);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = k < 4 ? longint'($urandom_range(0, 1024)) - 512 : longint'($signed(W'($urandom)));
                ws[i] = k < 4 ? longint'($urandom_range(0, 1024)) - 512 : longint'($signed(W'($urandom)));
            end
            run(longint'($signed(W'($urandom))) >>> (k < 4 ? 4 : 0), 3, 5);
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        x        = 16'sd1000;
        w        = 16'sd1000;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill(256, 256);       run(0, 2, 1);
        chk("fresh_1024", longint'(out), 1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
